// File: rtl/rv_mul_ctrl.sv
// Issue/control front end for the radix-4 Booth-Wallace multiplier (RV64M MUL group).
// Drives registered operands, waits MUL_LAT cycles, corrects signed high halves and returns the result.
module rv_mul_ctrl #(
    parameter int MUL_LAT = 1,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic            req_word_i,
    input  logic [63:0]     req_rs1_i,
    input  logic [63:0]     req_rs2_i,
    input  logic [RD_W-1:0] req_rd_i,
    input  logic            flush_i,
    output logic [63:0]     mul_op1_o,
    output logic [63:0]     mul_op2_o,
    input  logic [127:0]    mul_prod_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [63:0]     rsp_data_o,
    output logic [RD_W-1:0] rsp_rd_o,
    output logic            busy_o
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic             word_r;
    logic [RD_W-1:0]  rd_r;
    logic [127:0]     prod_r;
    logic             accept_s;
    logic             word_s;
    logic             sa_s;
    logic             sb_s;
    logic [63:0]      high_s;
    logic [63:0]      result_s;

    // The multiplier is unsigned; subtracting the other operand removes the sign-bit weight.
    function automatic logic [63:0] fix_high(input logic [127:0] p, input logic [63:0] a,
                                             input logic [63:0] b, input logic sa, input logic sb);
        logic [63:0] h;
        h = p[127:64];
        if (sa && a[63]) begin
            h = h - b;
        end else begin
            h = h;
        end
        if (sb && b[63]) begin
            h = h - a;
        end else begin
            h = h;
        end
        return h;
    endfunction

    function automatic logic [63:0] select_result(input logic [1:0] op, input logic word,
                                                  input logic [127:0] p, input logic [63:0] h);
        logic [63:0] r;
        case (op)
            2'b00:   r = word ? {{32{p[31]}}, p[31:0]} : p[63:0];
            default: r = h;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] shape_operand(input logic [63:0] rs, input logic word);
        return word ? {32'h0000_0000, rs[31:0]} : rs;
    endfunction

    assign req_ready_o = (state_r == ST_IDLE) & ~flush_i;
    assign accept_s    = req_valid_i & req_ready_o;
    assign word_s      = req_word_i & (req_op_i == 2'b00);

    // Signed-correction selection and result mux from the latched op.
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (op_r)
            2'b01:   begin sa_s = 1'b1; sb_s = 1'b1; end
            2'b10:   begin sa_s = 1'b1; sb_s = 1'b0; end
            default: begin sa_s = 1'b0; sb_s = 1'b0; end
        endcase
        high_s   = fix_high(prod_r, mul_op1_o, mul_op2_o, sa_s, sb_s);
        result_s = select_result(op_r, word_r, prod_r, high_s);
    end

    // Next-state logic; flush returns any busy state to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i || flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, operand, product and response registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_r        <= 2'b00;
            word_r      <= 1'b0;
            rd_r        <= {RD_W{1'b0}};
            prod_r      <= 128'h0;
            mul_op1_o   <= 64'h0;
            mul_op2_o   <= 64'h0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 64'h0;
            rsp_rd_o    <= {RD_W{1'b0}};
            busy_o      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_o  <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r      <= req_op_i;
                        word_r    <= word_s;
                        rd_r      <= req_rd_i;
                        mul_op1_o <= shape_operand(req_rs1_i, word_s);
                        mul_op2_o <= shape_operand(req_rs2_i, word_s);
                        cnt_r     <= {CNT_W{1'b0}};
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (!flush_i && (cnt_r == CNT_LAST)) begin
                        prod_r <= mul_prod_i;
                    end
                end
                ST_FIX: begin
                    if (!flush_i) begin
                        rsp_data_o  <= result_s;
                        rsp_rd_o    <= rd_r;
                        rsp_valid_o <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i || flush_i) begin
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: rsp_valid_o <= 1'b0;
            endcase
        end
    end

endmodule
